// File: rtl/src_ip_hash_issuer.sv
// Source-IP queue and hash-address issuer for the DDoS hash table. Parsed IPs
// are queued, hashed at the head and issued no faster than one per 3 cycles.
module src_ip_hash_issuer #(
  parameter int                                   MAX_DEPTH_BITS_HASH_TABLE = 14,
  parameter int                                   FIFO_DEPTH_BITS           = 4,
  parameter logic [MAX_DEPTH_BITS_HASH_TABLE-1:0] HASH_SEED                 = '0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [31:0]                          ip_in,
  input  logic                                 ip_vld,
  input  logic [1:0]                           table_state,
  input  logic                                 flush_1s,
  output logic [31:0]                          src_ip,
  output logic [MAX_DEPTH_BITS_HASH_TABLE-1:0] addr_hash,
  output logic                                 hash_vld,
  output logic                                 fifo_full,
  output logic                                 fifo_empty,
  output logic [31:0]                          drop_cnt,
  output logic [31:0]                          issue_cnt
);

  localparam int              HW         = MAX_DEPTH_BITS_HASH_TABLE;
  localparam int              NUM_CHUNKS = (32 + HW - 1) / HW;
  localparam int              PAD_W      = NUM_CHUNKS * HW;
  localparam int              AW         = FIFO_DEPTH_BITS;
  localparam int              DEPTH_N    = 2 ** AW;
  localparam logic [AW:0]     DEPTH      = {1'b1, {AW{1'b0}}};
  localparam logic [1:0]      TABLE_IDLE = 2'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD1 = 2'd1,
    HOLD2 = 2'd2
  } state_t;

  // Zero-pad the IP to whole HW-bit chunks and fold them together.
  function automatic logic [HW-1:0] hash_ip(input logic [31:0] ip);
    logic [PAD_W-1:0] padded;
    logic [HW-1:0]    acc;
    padded = PAD_W'(ip);
    acc    = HASH_SEED;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      acc ^= padded[i*HW +: HW];
    end
    return acc;
  endfunction

  logic [31:0] mem [DEPTH_N];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic [31:0]   head;
  logic          is_full;
  logic          push;
  logic          drop;
  logic          can_issue;
  logic          issue;
  state_t        state;
  state_t        next_state;

  assign head      = mem[rd_ptr];
  assign is_full   = (count == DEPTH);
  assign push      = ip_vld && !is_full;
  assign drop      = ip_vld && is_full;
  assign can_issue = (count != '0) && (table_state == TABLE_IDLE) && !flush_1s;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    count_next = count;
    unique case ({push, issue})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // NOTE: the storage array has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ip_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Two hold cycles cover the table's UPDATE and write-back, keeping the address stable.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (can_issue) begin
          issue      = 1'b1;
          next_state = HOLD1;
        end
      end
      HOLD1:   next_state = HOLD2;
      HOLD2:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_ip     <= '0;
      addr_hash  <= '0;
      hash_vld   <= 1'b0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      drop_cnt   <= '0;
      issue_cnt  <= '0;
    end else begin
      hash_vld   <= issue;
      fifo_full  <= (count_next == DEPTH);
      fifo_empty <= (count_next == '0);
      if (issue) begin
        src_ip    <= head;
        addr_hash <= hash_ip(head);
        issue_cnt <= issue_cnt + 32'd1;
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_src_ip_hash_issuer.sv
// Directed bench for src_ip_hash_issuer: issue timing, flush/table holds,
// overflow drops and reset during a hold, against hand-computed values.
module tb_src_ip_hash_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ip_in;
  logic        ip_vld;
  logic [1:0]  table_state;
  logic        flush_1s;
  logic [31:0] src_ip;
  logic [13:0] addr_hash;
  logic        hash_vld;
  logic        fifo_full;
  logic        fifo_empty;
  logic [31:0] drop_cnt;
  logic [31:0] issue_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  src_ip_hash_issuer dut (
    .clk         (clk),
    .reset       (reset),
    .ip_in       (ip_in),
    .ip_vld      (ip_vld),
    .table_state (table_state),
    .flush_1s    (flush_1s),
    .src_ip      (src_ip),
    .addr_hash   (addr_hash),
    .hash_vld    (hash_vld),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .drop_cnt    (drop_cnt),
    .issue_cnt   (issue_cnt)
  );

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Two quiet cycles then a pulse carrying the given IP and hash.
  task automatic expect_next_issue(input string tag, input logic [31:0] ip, input logic [31:0] h);
    logic seen;
    cyc();
    seen = hash_vld;
    cyc();
    seen |= hash_vld;
    cyc();
    check({tag, "_gap"}, 32'(seen), 32'd0);
    check({tag, "_vld"}, 32'(hash_vld), 32'd1);
    check({tag, "_ip"}, src_ip, ip);
    check({tag, "_hash"}, 32'(addr_hash), h);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1000000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    reset       = 1'b1;
    ip_in       = '0;
    ip_vld      = 1'b0;
    table_state = 2'd0;
    flush_1s    = 1'b0;
    cyc(2);

    // Reset state
    check("rst_src_ip", src_ip, 32'h0);
    check("rst_addr", 32'(addr_hash), 32'h0);
    check("rst_vld", 32'(hash_vld), 32'd0);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_drop", drop_cnt, 32'd0);
    check("rst_issue", issue_cnt, 32'd0);
    reset = 1'b0;
    cyc();

    // 1: single IP, 1-cycle latency, values held
    ip_in  = 32'hC0A80001;
    ip_vld = 1'b1;
    cyc();
    ip_vld = 1'b0;
    check("t1_empty_after_push", 32'(fifo_empty), 32'd0);
    check("t1_no_vld_yet", 32'(hash_vld), 32'd0);
    cyc();
    check("t1_vld", 32'(hash_vld), 32'd1);
    check("t1_ip", src_ip, 32'hC0A80001);
    check("t1_hash", 32'(addr_hash), 32'h02AD);
    check("t1_issue_cnt", issue_cnt, 32'd1);
    check("t1_empty_after_pop", 32'(fifo_empty), 32'd1);
    cyc();
    check("t1_vld_one_cycle", 32'(hash_vld), 32'd0);
    cyc(2);
    check("t1_ip_held", src_ip, 32'hC0A80001);
    check("t1_hash_held", 32'(addr_hash), 32'h02AD);

    // 2: back-to-back strobes, pulses 3 cycles apart
    ip_in  = 32'hC0A80001;
    ip_vld = 1'b1;
    cyc();
    ip_in  = 32'h0A000005;
    cyc();
    ip_vld = 1'b0;
    check("t2_first_vld", 32'(hash_vld), 32'd1);
    check("t2_first_hash", 32'(addr_hash), 32'h02AD);
    expect_next_issue("t2_second", 32'h0A000005, 32'h2805);
    check("t2_issue_cnt", issue_cnt, 32'd3);

    // 3: 11-cycle flush then a long FLUSH walk, then FIFO-order drain
    flush_1s = 1'b1;
    ip_vld   = 1'b1;
    ip_in    = 32'h12345678;
    cyc();
    seen = hash_vld;
    ip_in = 32'hFFFFFFFF;
    cyc();
    seen |= hash_vld;
    ip_in = 32'h80000000;
    cyc();
    seen |= hash_vld;
    ip_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      seen |= hash_vld;
    end
    check("t3_quiet_flush", 32'(seen), 32'd0);
    flush_1s    = 1'b0;
    table_state = 2'd2;
    seen        = 1'b0;
    for (int i = 0; i < 16385; i++) begin
      cyc();
      seen |= hash_vld;
    end
    check("t3_quiet_table", 32'(seen), 32'd0);
    table_state = 2'd0;
    cyc();
    check("t3_a_vld", 32'(hash_vld), 32'd1);
    check("t3_a_ip", src_ip, 32'h12345678);
    check("t3_a_hash", 32'(addr_hash), 32'h1EA8);
    expect_next_issue("t3_b", 32'hFFFFFFFF, 32'h000F);
    expect_next_issue("t3_c", 32'h80000000, 32'h0008);
    check("t3_issue_cnt", issue_cnt, 32'd6);

    // 4: overflow while the table is busy
    table_state = 2'd2;
    ip_vld      = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ip_in = 32'h00001000 + 32'(i);
      cyc();
      if (i == 14) check("t4_not_full_15", 32'(fifo_full), 32'd0);
      if (i == 15) check("t4_full_16", 32'(fifo_full), 32'd1);
    end
    check("t4_drop_cnt", drop_cnt, 32'd4);
    check("t4_full_end", 32'(fifo_full), 32'd1);

    // 5: push while full with a pop in the same cycle
    table_state = 2'd0;
    ip_in       = 32'hDEADBEEF;
    cyc();
    ip_vld = 1'b0;
    check("t5_vld", 32'(hash_vld), 32'd1);
    check("t5_ip0", src_ip, 32'h00001000);
    check("t5_drop_cnt", drop_cnt, 32'd5);
    check("t5_full_cleared", 32'(fifo_full), 32'd0);
    for (int k = 1; k < 16; k++) begin
      expect_next_issue("t4_order", 32'h00001000 + 32'(k), 32'h00001000 + 32'(k));
    end
    check("t5_drained_empty", 32'(fifo_empty), 32'd1);
    cyc();
    seen = hash_vld;
    cyc();
    seen |= hash_vld;
    cyc();
    seen |= hash_vld;
    check("t5_dropped_not_issued", 32'(seen), 32'd0);
    check("t5_issue_cnt", issue_cnt, 32'd22);

    // 6: reset in HOLD1 with 5 IPs still queued
    table_state = 2'd2;
    ip_vld      = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ip_in = 32'h00002000 + 32'(i);
      cyc();
    end
    ip_vld      = 1'b0;
    table_state = 2'd0;
    cyc();
    check("t6_issue_vld", 32'(hash_vld), 32'd1);
    check("t6_issue_ip", src_ip, 32'h00002000);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("t6_src_ip", src_ip, 32'h0);
    check("t6_addr", 32'(addr_hash), 32'h0);
    check("t6_vld", 32'(hash_vld), 32'd0);
    check("t6_full", 32'(fifo_full), 32'd0);
    check("t6_empty", 32'(fifo_empty), 32'd1);
    check("t6_drop", drop_cnt, 32'd0);
    check("t6_issue", issue_cnt, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      seen |= hash_vld;
    end
    check("t6_no_issue_after_reset", 32'(seen), 32'd0);
    ip_in  = 32'h0A000005;
    ip_vld = 1'b1;
    cyc();
    ip_vld = 1'b0;
    cyc();
    check("t6_new_vld", 32'(hash_vld), 32'd1);
    check("t6_new_hash", 32'(addr_hash), 32'h2805);
    check("t6_new_issue_cnt", issue_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
